systolic_out_requant: RTL
=========================

# systolic_out_requant

Downstream stage of the weight-stationary systolic accumulator array. Takes the array's per-column accumulator outputs, which emerge diagonally skewed by one cycle per column, realigns them into one vector, then rescales each lane by an arithmetic right shift with optional rounding and saturates it to the activation width. Results go into a small output FIFO with a valid/ready handshake, which feeds the activation write-back path.

## Interface

**Parameters**
- `width`, 10: number of array columns (output lanes).
- `BW_ACCU`, 32: accumulator width of the incoming column sums.
- `BW_OUT`, 8: signed width of each requantized output lane.
- `DEPTH`, 4: output FIFO depth in vectors; power of two, ≥2.

**Ports**
- `clk`, input, 1: single clock; all logic is rising-edge.
- `reset`, input, 1: asynchronous, active-low.
- `acc_in[width-1:0]`, input, signed BW_ACCU each: array column outputs.
- `in_valid`, input, 1: high in the cycle lane 0 of a result vector is on `acc_in[0]`.
- `PE_clear_acc`, input, 1: synchronous flush of in-flight alignment state and the overflow flag.
- `PE_res_shift_num`, input, 8: right-shift amount, sampled per vector.
- `out_data[width-1:0]`, output, signed BW_OUT each: FIFO head vector.
- `out_valid`, output, 1: `out_data` holds a vector.
- `out_ready`, input, 1: consumer accepts the head when `out_valid && out_ready`.
- `ovf_sticky`, output, 1: at least one aligned vector was dropped because the FIFO was full.

## Operation

- **Skew model.** For a vector tagged by `in_valid` at cycle t, lane j's value is on `acc_in[j]` at cycle t+j.
- **Alignment.** Lane j passes through a delay line of width-1-j registers. A valid-tag shift register of width-1 stages tracks `in_valid`. At t+width-1 all lanes are aligned and the tag is at the tail.
- **Shift sampling.** `PE_res_shift_num` is sampled at the `in_valid` cycle and carried with the tag, so a mid-stream shift change does not corrupt earlier vectors.
- **Requantize, per lane, shift s:**
  - Arithmetic right shift by s, computed in BW_ACCU+1 bits.
  - s ≥ BW_ACCU yields 0 for non-negative inputs and -1 for negative inputs (pre-round).
  - Saturate to [-2^(BW_OUT-1), 2^(BW_OUT-1)-1].
  - s = 0 passes the value through unchanged, with saturation only.
- **FIFO.**
  - Write at the requant register stage. Read on `out_valid && out_ready`.
  - Write when full: vector dropped, `ovf_sticky` set.
  - Write when full with a read in the same cycle: write accepted, count unchanged.
  - Write and read on an empty FIFO: the new vector becomes visible the next cycle; there is no combinational bypass.
- **Back-to-back input.** `in_valid` may assert every cycle; the alignment path is fully pipelined.
- **`PE_clear_acc`.** Zeroes delay lines, valid tags and `ovf_sticky`, and discards in-flight vectors. It does not touch FIFO contents. A vector whose `in_valid` coincides with clear is discarded.

## Timing

- **Reset values.**
  - `out_valid` = 0, `out_data` = 0, `ovf_sticky` = 0.
  - FIFO empty; all delay lines and tags = 0.
- **Latency.** `in_valid` at cycle t gives:
  - aligned vector at t+width-1;
  - requant register and FIFO write at t+width;
  - `out_valid` at t+width+1 when the FIFO was empty.
- **Throughput.** One vector per cycle in and one per cycle out.
- **Handshake rules.**
  - `out_data` is stable while `out_valid && !out_ready`.
  - `out_valid` never depends combinationally on `out_ready`.
- **Reset mid-operation.** All in-flight and queued vectors are lost, and outputs return to their reset values immediately (asynchronous).

## Configuration

- **`SYS_REQUANT_ROUND_EN` defined:** round half up. Add 2^(s-1) before the shift when s > 0, then saturate.
- **Not defined:** truncate, i.e. floor via arithmetic shift. The rounding adder is absent.

## Structure

- **Shared package `systolic_pkg`:**
  - `BW_ACCU` and `BW_OUT` defaults;
  - the lane typedef `logic signed [BW_OUT-1:0]`;
  - the `sat_shift` function (shift, round, saturate) used by the requant stage and the bench model.
- **One sub-module, `vec_fifo`:** parameterised synchronous FIFO of packed vectors with full/empty/count. The alignment and requant logic stays in the top.

## Test plan

- **Single vector, round enabled:** width=10, BW_OUT=8, s=4, all lanes 291 with correct per-lane skew → `out_valid` at t+11, every lane 18.
- **Saturation:** s=2, lane 0 = 1000, lane 1 = -1000 → lane 0 = 127, lane 1 = -128.
- **Rounding macro:** s=3, lane = -20 → -2 with `SYS_REQUANT_ROUND_EN` defined, -3 without.
- **Full FIFO:** `out_ready`=0, five consecutive vectors with DEPTH=4 → four stored, fifth dropped, `ovf_sticky`=1. Raising `out_ready` then drains the four in order over four cycles.
- **Shift change and back-to-back:** two vectors on consecutive cycles, first with s=1, second with s=0 → outputs use 1 and 0 respectively, on consecutive cycles.
- **Clear mid-flight:** `PE_clear_acc` at t+5 after `in_valid` at t, FIFO holding one vector → in-flight vector never appears, queued vector still output, `ovf_sticky`=0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared widths, lane type and the per-lane shift/round/saturate helper for the systolic output path.
// SYS_REQUANT_ROUND_EN selects round-half-up; without it the shift floors.
package systolic_pkg;

    localparam int unsigned BW_ACCU_DFLT = 32;
    localparam int unsigned BW_OUT_DFLT  = 8;

    typedef logic signed [BW_OUT_DFLT-1:0] lane_t;

    // Arithmetic right shift with optional rounding, saturated to a signed bw_out range.
    // The 64-bit working width covers any bw_accu up to 62 without overflow of the round add.
    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] acc,
        input logic        [7:0]  s,
        input int unsigned        bw_accu,
        input int unsigned        bw_out
    );
        logic signed [63:0] tmp;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bw_out - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bw_out - 1));
        if (32'(s) >= bw_accu) begin
`ifdef SYS_REQUANT_ROUND_EN
            tmp = 64'sd0;
`else
            tmp = acc[63] ? -64'sd1 : 64'sd0;
`endif
        end else begin
            tmp = acc;
`ifdef SYS_REQUANT_ROUND_EN
            if (s != 8'd0) begin
                tmp = tmp + (64'sd1 <<< (s - 8'd1));
            end
`endif
            tmp = tmp >>> s;
        end
        if (tmp > hi) begin
            tmp = hi;
        end else if (tmp < lo) begin
            tmp = lo;
        end
        return tmp;
    endfunction

endpackage

// File: rtl/vec_fifo.sv
// Synchronous FIFO of packed vectors; head is presented directly from storage, valid/full are registered.
module vec_fifo #(
    parameter int unsigned DW    = 80,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          rd_fire;
    logic          wr_fire;

    // A write into a full FIFO still lands when the head leaves in the same cycle.
    always_comb begin
        rd_fire   = rd_valid && rd_ready;
        wr_fire   = wr_en && (!full || rd_fire);
        count_nxt = count;
        if (wr_fire && !rd_fire) begin
            count_nxt = count + CW'(1);
        end else if (!wr_fire && rd_fire) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                mem[k] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            full     <= 1'b0;
        end else begin
            if (wr_fire) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_nxt;
            rd_valid <= (count_nxt != '0);
            full     <= (count_nxt == CW'(DEPTH));
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/systolic_out_requant.sv
// De-skews systolic column sums, requantizes each lane (shift, optional round, saturate) and queues vectors.
// Rounding is enabled by defining SYS_REQUANT_ROUND_EN.
module systolic_out_requant
    import systolic_pkg::*;
#(
    parameter int unsigned width   = 10,
    parameter int unsigned BW_ACCU = BW_ACCU_DFLT,
    parameter int unsigned BW_OUT  = BW_OUT_DFLT,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [BW_ACCU-1:0] acc_in [width-1:0],
    input  logic                      in_valid,
    input  logic                      PE_clear_acc,
    input  logic        [7:0]         PE_res_shift_num,
    output logic signed [BW_OUT-1:0]  out_data [width-1:0],
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      ovf_sticky
);
    localparam int unsigned TAGS = width - 1;
    localparam int unsigned VW   = width * BW_OUT;

    logic signed [BW_ACCU-1:0]     aligned [width];
    logic                          tag_v [TAGS];
    logic [7:0]                    tag_s [TAGS];
    logic [width-1:0][BW_OUT-1:0]  rq_nxt;
    logic [width-1:0][BW_OUT-1:0]  rq_data;
    logic                          rq_valid;
    logic                          fifo_wr;
    logic                          fifo_full;
    logic [width-1:0][BW_OUT-1:0]  fifo_rd;

    // Lane j waits width-1-j cycles so every lane lines up with the last column.
    for (genvar j = 0; j < int'(width); j++) begin : g_lane
        localparam int unsigned D = width - 1 - j;
        if (D == 0) begin : g_direct
            assign aligned[j] = acc_in[j];
        end else begin : g_dly
            logic signed [BW_ACCU-1:0] dl [D];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < int'(D); k++) dl[k] <= '0;
                end else if (PE_clear_acc) begin
                    for (int k = 0; k < int'(D); k++) dl[k] <= '0;
                end else begin
                    dl[0] <= acc_in[j];
                    for (int k = 1; k < int'(D); k++) dl[k] <= dl[k-1];
                end
            end
            assign aligned[j] = dl[D-1];
        end
    end

    // Valid tag travels with its own shift amount so later shift changes do not leak back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < int'(TAGS); k++) begin
                tag_v[k] <= 1'b0;
                tag_s[k] <= '0;
            end
        end else if (PE_clear_acc) begin
            for (int k = 0; k < int'(TAGS); k++) begin
                tag_v[k] <= 1'b0;
                tag_s[k] <= '0;
            end
        end else begin
            tag_v[0] <= in_valid;
            tag_s[0] <= PE_res_shift_num;
            for (int k = 1; k < int'(TAGS); k++) begin
                tag_v[k] <= tag_v[k-1];
                tag_s[k] <= tag_s[k-1];
            end
        end
    end

    always_comb begin
        rq_nxt = '0;
        for (int j = 0; j < int'(width); j++) begin
            rq_nxt[j] = BW_OUT'(sat_shift(64'(aligned[j]), tag_s[TAGS-1], BW_ACCU, BW_OUT));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rq_valid <= 1'b0;
            rq_data  <= '0;
        end else begin
            rq_valid <= tag_v[TAGS-1] && !PE_clear_acc;
            rq_data  <= rq_nxt;
        end
    end

    // A clear also discards the vector sitting in the requant register.
    assign fifo_wr = rq_valid && !PE_clear_acc;

    vec_fifo #(
        .DW    (VW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (fifo_wr),
        .wr_data  (rq_data),
        .rd_ready (out_ready),
        .rd_data  (fifo_rd),
        .rd_valid (out_valid),
        .full     (fifo_full)
    );

    always_comb begin
        for (int j = 0; j < int'(width); j++) begin
            out_data[j] = $signed(fifo_rd[j]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_sticky <= 1'b0;
        end else if (PE_clear_acc) begin
            ovf_sticky <= 1'b0;
        end else if (rq_valid && fifo_full && !(out_valid && out_ready)) begin
            ovf_sticky <= 1'b1;
        end
    end

endmodule
